btb_table: RTL and testbench

BTB_TABLE -- requirements
Module: btb_table

---
 rtl/btb_table.sv | 94 +++++++++
 tb/tb_btb_table.sv | 137 +++++++++++++
 2 files changed

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer with combinational lookup and
// taken-branch update.
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous active-low reset; clears every valid bit
//   PCF          fetch PC to look up
//   EXpc         PC of the branch resolving in EX
//   BranchE      EX branch resolved taken
//   BranchTypeE  EX branch type; nonzero means a conditional branch is present
//   BrNPC        EX computed branch target
//   BTBflush     invalidate all entries at the next edge; beats a same-cycle update
//   BTBhit       PCF matches a valid entry
//   BTBtarget    stored target on a hit, 0 otherwise
//   BTBstat_*    saturating hit/update/replacement counters (only with BTB_STATS_EN)
// Build option: define BTB_STATS_EN to compile in the statistics counters.
module btb_table #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic [31:0] EXpc,
    input  logic        BranchE,
    input  logic [2:0]  BranchTypeE,
    input  logic [31:0] BrNPC,
    input  logic        BTBflush,
`ifdef BTB_STATS_EN
    output logic [31:0] BTBstat_hit,
    output logic [31:0] BTBstat_upd,
    output logic [31:0] BTBstat_repl,
`endif
    output logic        BTBhit,
    output logic [31:0] BTBtarget
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             upd;

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[31:IDX_W+2];
    assign e_idx = EXpc[IDX_W+1:2];
    assign e_tag = EXpc[31:IDX_W+2];

    // Not-taken resolutions leave the entry alone; direction lives in the BHT.
    assign upd = BranchE && (BranchTypeE != 3'd0) && !BTBflush;

    assign BTBhit    = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign BTBtarget = BTBhit ? tgt_mem[f_idx] : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid <= '0;
        else if (BTBflush)
            valid <= '0;
        else if (upd)
            valid[e_idx] <= 1'b1;
    end

    // Tag/target payload needs no reset: a cleared valid bit masks it.
    always_ff @(posedge clk) begin
        if (upd) begin
            tag_mem[e_idx] <= e_tag;
            tgt_mem[e_idx] <= BrNPC;
        end
    end

`ifdef BTB_STATS_EN
    logic repl;

    assign repl = upd && valid[e_idx] && (tag_mem[e_idx] != e_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BTBstat_hit  <= '0;
            BTBstat_upd  <= '0;
            BTBstat_repl <= '0;
        end else begin
            if (BTBhit && BTBstat_hit != '1)
                BTBstat_hit <= BTBstat_hit + 32'd1;
            if (upd && BTBstat_upd != '1)
                BTBstat_upd <= BTBstat_upd + 32'd1;
            if (repl && BTBstat_repl != '1)
                BTBstat_repl <= BTBstat_repl + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_btb_table.sv
// tb_btb_table: directed vector bench for btb_table
module tb_btb_table;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, EXpc, BrNPC;
    logic        BranchE, BTBflush;
    logic [2:0]  BranchTypeE;
    logic        BTBhit;
    logic [31:0] BTBtarget;
`ifdef BTB_STATS_EN
    logic [31:0] BTBstat_hit, BTBstat_upd, BTBstat_repl;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_hits = 0;

    always #5 clk = ~clk;

    btb_table #(.IDX_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .PCF(PCF),
        .EXpc(EXpc),
        .BranchE(BranchE),
        .BranchTypeE(BranchTypeE),
        .BrNPC(BrNPC),
        .BTBflush(BTBflush),
`ifdef BTB_STATS_EN
        .BTBstat_hit(BTBstat_hit),
        .BTBstat_upd(BTBstat_upd),
        .BTBstat_repl(BTBstat_repl),
`endif
        .BTBhit(BTBhit),
        .BTBtarget(BTBtarget)
    );

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] expc;
        logic        br;
        logic [2:0]  btype;
        logic [31:0] npc;
        logic        flush;
        logic        exp_hit;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t v [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pcf, input logic [31:0] expc, input logic br,
                         input logic [2:0] btype, input logic [31:0] npc, input logic flush);
        PCF = pcf; EXpc = expc; BranchE = br; BranchTypeE = btype; BrNPC = npc; BTBflush = flush;
    endtask

    initial begin
        // Outputs are checked before the edge that applies the vector's update.
        v[0]  = '{32'h40, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[1]  = '{32'h40, 32'h44, 1'b1, 3'd1, 32'h100, 1'b0, 1'b0, 32'h0};
        v[2]  = '{32'h44, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b1, 32'h100};
        v[3]  = '{32'h84, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[4]  = '{32'h48, 32'h48, 1'b1, 3'd2, 32'h300, 1'b0, 1'b0, 32'h0};
        v[5]  = '{32'h48, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b1, 32'h300};
        v[6]  = '{32'h44, 32'h44, 1'b0, 3'd1, 32'h999, 1'b0, 1'b1, 32'h100};
        v[7]  = '{32'h44, 32'h44, 1'b1, 3'd0, 32'h555, 1'b0, 1'b1, 32'h100};
        v[8]  = '{32'h44, 32'h84, 1'b1, 3'd1, 32'h200, 1'b0, 1'b1, 32'h100};
        v[9]  = '{32'h44, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[10] = '{32'h84, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b1, 32'h200};
        v[11] = '{32'h48, 32'h50, 1'b1, 3'd1, 32'h400, 1'b1, 1'b1, 32'h300};
        v[12] = '{32'h48, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[13] = '{32'h50, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[14] = '{32'h84, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b0, 32'h0};
        v[15] = '{32'h84, 32'h84, 1'b1, 3'd3, 32'h600, 1'b0, 1'b0, 32'h0};
        v[16] = '{32'h84, 32'h0,  1'b0, 3'd0, 32'h0,   1'b0, 1'b1, 32'h600};

        rst = 1'b0;
        drive(32'h40, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        #2;
        chk("reset_hit", {31'd0, BTBhit}, 32'd0);
        chk("reset_tgt", BTBtarget, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
`ifdef BTB_STATS_EN
            if (i == 12) chk("stat_upd_after_flush", BTBstat_upd, 32'd3);
            if (i == 10) chk("stat_repl_after_replace", BTBstat_repl, 32'd1);
`endif
            drive(v[i].pcf, v[i].expc, v[i].br, v[i].btype, v[i].npc, v[i].flush);
            #1;
            chk($sformatf("v%0d_hit", i), {31'd0, BTBhit}, {31'd0, v[i].exp_hit});
            chk($sformatf("v%0d_tgt", i), BTBtarget, v[i].exp_tgt);
            if (v[i].exp_hit) exp_hits++;
        end
        @(negedge clk);
        drive(32'h84, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        #1;
        chk("pre_areset_hit", {31'd0, BTBhit}, 32'd1);
`ifdef BTB_STATS_EN
        chk("stat_hit", BTBstat_hit, exp_hits);
        chk("stat_upd", BTBstat_upd, 32'd4);
        chk("stat_repl", BTBstat_repl, 32'd1);
`endif
        // Asynchronous reset between edges, held across an attempted update.
        #1;
        rst = 1'b0;
        #1;
        chk("areset_hit", {31'd0, BTBhit}, 32'd0);
        chk("areset_tgt", BTBtarget, 32'd0);
`ifdef BTB_STATS_EN
        chk("areset_stat_hit", BTBstat_hit, 32'd0);
        chk("areset_stat_upd", BTBstat_upd, 32'd0);
        chk("areset_stat_repl", BTBstat_repl, 32'd0);
`endif
        drive(32'h48, 32'h48, 1'b1, 3'd1, 32'h700, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h48, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0);
        #1;
        chk("reset_wins_hit", {31'd0, BTBhit}, 32'd0);
        PCF = 32'h84;
        #1;
        chk("post_reset_84_hit", {31'd0, BTBhit}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
